// File: rtl/bram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous-read block RAM.
// Issues at most one registered RAM command per cycle and routes read data back via a tag pipeline.
module bram_rr_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic              w_elig0;
    logic              w_elig1;
    logic              w_any;
    logic              w_sel1;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_last;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_din;
    logic [READ_LATENCY-1:0] r_tag_vld;
    logic [READ_LATENCY-1:0] r_tag_id;

    // A requester whose grant is showing this cycle still has its old request up; skip it.
    assign w_elig0 = req0 & ~r_gnt0;
    assign w_elig1 = req1 & ~r_gnt1;
    assign w_any   = w_elig0 | w_elig1;
    assign w_sel1  = w_elig1 & (~w_elig0 | ~r_last);

    assign w_sel_we    = w_sel1 ? we1    : we0;
    assign w_sel_addr  = w_sel1 ? addr1  : addr0;
    assign w_sel_wdata = w_sel1 ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_last     <= 1'b1;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_tag_vld  <= '0;
            r_tag_id   <= '0;
        end else begin
            r_gnt0   <= w_any & ~w_sel1;
            r_gnt1   <= w_sel1;
            r_ram_en <= w_any;
            r_ram_we <= w_any & w_sel_we;
            if (w_any) begin
                r_last     <= w_sel1;
                r_ram_addr <= w_sel_addr;
                r_ram_din  <= w_sel_we ? w_sel_wdata : '0;
            end
            // Tag entry enters alongside the command; the registered rvalid adds the final cycle.
            r_tag_vld[0] <= w_any & ~w_sel_we;
            r_tag_id[0]  <= w_sel1;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
            end
            r_rvalid0 <= r_tag_vld[READ_LATENCY-1] & ~r_tag_id[READ_LATENCY-1];
            r_rvalid1 <= r_tag_vld[READ_LATENCY-1] &  r_tag_id[READ_LATENCY-1];
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata    = ram_dout;
    assign ram_en   = r_ram_en;
    assign ram_we   = r_ram_we;
    assign ram_addr = r_ram_addr;
    assign ram_din  = r_ram_din;

endmodule

// File: doc/bram_rr_arbiter.md
# bram_rr_arbiter

Round-robin arbiter that shares one single-port block RAM (16 x 8, synchronous read) between two independent requesters. It registers one RAM command per cycle on the RAM port and tracks outstanding reads through a latency-matched tag pipeline. It returns read data to the correct requester with a per-requester valid pulse. It sits between the requester logic and the block-RAM wrapper, and runs in the divided clock domain that the RAM uses.

## Interface

- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width
- READ_LATENCY, 1, cycles from the RAM command cycle to valid `ram_dout`; legal range 1..3
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  request from requester 0 / 1; held high until granted
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  in  ADDR_W  request address; stable while req is high
- wdata0 / wdata1  in  DATA_W  write data; stable while req is high
- gnt0 / gnt1  out  1  one-cycle grant pulse, coincident with the RAM command
- rvalid0 / rvalid1  out  1  one-cycle pulse; `rdata` is valid for that requester
- rdata  out  DATA_W  combinational pass-through of `ram_dout`
- ram_en  out  1  RAM enable, registered
- ram_we  out  1  RAM write enable, registered
- ram_addr  out  ADDR_W  RAM address, registered
- ram_din  out  DATA_W  RAM write data, registered
- ram_dout  in  DATA_W  RAM read data

## Operation

- **Eligibility:** requester i is eligible in a cycle when `req_i`=1 and `gnt_i`=0 in that cycle. A requester is never re-granted on its stale request in its own grant cycle.
- **Arbitration:** one pointer bit `last` holds the most recently granted requester.
  - If both requesters are eligible, grant the one that is not `last`.
  - If only one is eligible, grant it.
  - If neither is eligible, issue no command.
- **On a grant at edge E (grant to i):**
  - Load `ram_en`=1, `ram_we`=`we_i`, `ram_addr`=`addr_i`, and `ram_din`=`wdata_i` (or 0 on a read).
  - Set `gnt_i`=1 and set `last`=i.
  - With no grant, `ram_en`=0 and `ram_we`=0; `ram_addr` and `ram_din` hold their values.
- **Read tag pipeline:** a shift register READ_LATENCY deep of {valid, id}.
  - Entry loaded at the grant edge: valid = (read granted), id = i.
  - The pipeline output drives `rvalid0` / `rvalid1`.
  - A write never produces an rvalid.
- **Ordering:** commands reach the RAM in grant order. A read granted after a write to the same address returns the new data.
- **Throughput:**
  - Up to one command per cycle total.
  - A single requester gets at most one grant every 2 cycles.
  - With both requesting continuously, grants alternate 0,1,0,1…
- **Reset** (`rst`=1 at an edge):
  - `gnt0`, `gnt1`, `rvalid0`, `rvalid1`, `ram_en`, and `ram_we` = 0.
  - `ram_addr` and `ram_din` = 0.
  - Tag pipeline cleared and `last`=1, so requester 0 wins the first tie.
  - Reads outstanding when reset arrives are dropped: no rvalid after reset, even if the RAM still produces data.
  - Requests present during reset are ignored. Arbitration starts at the first edge with `rst`=0.

## Timing

- **Request to command:** `req_i` high in cycle t with i eligible and winning → `gnt_i` and the RAM command are both high in cycle t+1 (1-cycle latency).
- **Read return:**
  - The RAM command occupies cycle c.
  - `rvalid_i`=1 in cycle c+READ_LATENCY, and `rdata`=`ram_dout` in that same cycle.
  - Round-trip latency from req to rvalid is 1+READ_LATENCY cycles.
- **Pipelined reads:** back-to-back reads from alternating requesters produce back-to-back rvalid pulses, in the same order and with the same spacing.
- **Handshake rules:**
  - The requester keeps req, we, addr and wdata stable until it sees `gnt_i`.
  - In the cycle after `gnt_i`, the requester may either drop req or present a new request.
- **Simultaneous reset and request:** reset wins.
- **Pulse widths:** `gnt_i` and `rvalid_i` are never high for 2 consecutive cycles to the same requester from a single request.

## Test plan

- **Reset:** hold `rst`=1 for 3 cycles with req0=req1=1 → all outputs 0 throughout. After release, first grant is `gnt0` one cycle later, with `ram_addr`=addr0.
- **Single write then read** (req0 only): write addr 4'h3, data 8'hA5, then read 4'h3.
  - `ram_we`=1 in the write grant cycle.
  - `rvalid0`=1 exactly READ_LATENCY cycles after the read grant, with `rdata`=8'hA5.
  - `rvalid1` stays 0.
- **Contention:** req0 and req1 both held for 8 reads at addresses 0..7 (each requester advances its own address). Preload mem[k]=8'h10+k.
  - Grants alternate 0,1,0,1 with one command per cycle.
  - Each rvalid carries its requester's data, in issue order.
- **Single-requester throughput:** req1 held high for 4 reads → `gnt1` high on alternate cycles only, and `ram_en` has idle cycles in between.
- **Reset mid-read:** with READ_LATENCY=2, grant a read to requester 0, then assert `rst` in the next cycle → no `rvalid0` ever appears for that read.
- **Latency sweep:** run the single write-then-read scenario with READ_LATENCY = 1, 2 and 3 → rvalid timing shifts exactly with the parameter, with correct data in each case.
